// File: rtl/cpsr_unit_pkg.sv
// cpsr_unit_pkg: shared CPSR bit indices, processor mode encodings and small
// helpers for mode legality, SPSR banking and MSR byte-lane merging. The same
// bit indices are used by the condition-check logic.
package cpsr_unit_pkg;

    localparam int CPSR_N    = 31;
    localparam int CPSR_Z    = 30;
    localparam int CPSR_C    = 29;
    localparam int CPSR_V    = 28;
    localparam int CPSR_I    = 7;
    localparam int CPSR_F    = 6;
    localparam int CPSR_T    = 5;
    localparam int CPSR_M_HI = 4;
    localparam int CPSR_M_LO = 0;

    localparam logic [31:0] RESET_CPSR_DEFAULT = 32'h0000_00D3;

    typedef enum logic [4:0] {
        MODE_USR = 5'b10000,
        MODE_FIQ = 5'b10001,
        MODE_IRQ = 5'b10010,
        MODE_SVC = 5'b10011,
        MODE_ABT = 5'b10111,
        MODE_UND = 5'b11011,
        MODE_SYS = 5'b11111
    } mode_e;

    // True for the seven architecturally defined modes.
    function automatic logic mode_legal(input logic [4:0] mode);
        case (mode)
            MODE_USR, MODE_FIQ, MODE_IRQ, MODE_SVC,
            MODE_ABT, MODE_UND, MODE_SYS: return 1'b1;
            default:                      return 1'b0;
        endcase
    endfunction

    // True for the modes that own a banked SPSR (USR/SYS share none).
    function automatic logic mode_banked(input logic [4:0] mode);
        case (mode)
            MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_ABT, MODE_UND: return 1'b1;
            default:                                          return 1'b0;
        endcase
    endfunction

    // Physical slot of a banked SPSR; non-banked modes map to slot 0 and
    // must be filtered with mode_banked() by the caller.
    function automatic logic [2:0] bank_idx(input logic [4:0] mode);
        case (mode)
            MODE_FIQ: return 3'd0;
            MODE_IRQ: return 3'd1;
            MODE_SVC: return 3'd2;
            MODE_ABT: return 3'd3;
            MODE_UND: return 3'd4;
            default:  return 3'd0;
        endcase
    endfunction

    // Replace each enabled byte lane {f,s,x,c} of old_v with new_v.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  fields);
        logic [31:0] res_v;
        res_v = old_v;
        for (int i = 0; i < 4; i++) begin
            if (fields[i]) begin
                res_v[i*8 +: 8] = new_v[i*8 +: 8];
            end else begin
                res_v[i*8 +: 8] = old_v[i*8 +: 8];
            end
        end
        return res_v;
    endfunction

endpackage

// File: rtl/cpsr_unit_spsr_bank.sv
// cpsr_unit_spsr_bank: five banked SPSRs (FIQ, IRQ, SVC, ABT, UND).
//   clk, reset   : clock and synchronous active-high reset (clears all SPSRs)
//   we/wmode/wdata : single write port; writes to non-banked modes are dropped
//   rd_mode      : mode selecting the read port
//   rd_data      : SPSR of rd_mode, 0 for USR/SYS or illegal modes
//   legal        : rd_mode is one of the seven defined modes
module cpsr_unit_spsr_bank
    import cpsr_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  wmode,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd_mode,
    output logic [31:0] rd_data,
    output logic        legal
);

    logic [31:0] bank_r [5];
    logic [31:0] rd_data_s;

    // Banked SPSR storage with a single write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 5; i++) begin
                bank_r[i] <= 32'd0;
            end
        end else if (we && mode_banked(wmode)) begin
            bank_r[bank_idx(wmode)] <= wdata;
        end
    end

    // Read mux; modes without an SPSR read as zero.
    always_comb begin
        rd_data_s = 32'd0;
        if (mode_banked(rd_mode)) begin
            rd_data_s = bank_r[bank_idx(rd_mode)];
        end else begin
            rd_data_s = 32'd0;
        end
    end

    assign rd_data = rd_data_s;
    assign legal   = mode_legal(rd_mode);

endmodule

// File: rtl/cpsr_unit.sv
// cpsr_unit: CPSR plus banked SPSRs with prioritised update
// (exception entry > exception return > MSR CPSR > MSR SPSR > ALU flags).
//   clk, reset     : clock, synchronous active-high reset
//   inst_valid     : gates every instruction-originated update
//   flag_we/alu_nzcv/nzcv_mask : per-flag ALU update
//   msr_we/msr_spsr/msr_fields/msr_data : MSR write to CPSR or current SPSR
//   exc_req/exc_mode/exc_fiq   : exception entry (not gated by inst_valid)
//   exc_ret        : return, CPSR <= SPSR of current mode
//   cpsr           : registered CPSR
//   cpsr_next      : value cpsr takes at the next edge (same-cycle bypass)
//   spsr           : SPSR of the current registered mode, 0 in USR/SYS
//   exc_err        : registered one-cycle pulse on illegal entry/return
module cpsr_unit
    import cpsr_unit_pkg::*;
#(
    parameter logic [31:0] RESET_CPSR = 32'h0000_00D3
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_valid,
    input  logic        flag_we,
    input  logic [3:0]  alu_nzcv,
    input  logic [3:0]  nzcv_mask,
    input  logic        msr_we,
    input  logic        msr_spsr,
    input  logic [3:0]  msr_fields,
    input  logic [31:0] msr_data,
    input  logic        exc_req,
    input  logic [4:0]  exc_mode,
    input  logic        exc_fiq,
    input  logic        exc_ret,
    output logic [31:0] cpsr,
    output logic [31:0] cpsr_next,
    output logic [31:0] spsr,
    output logic        exc_err
);

    logic [31:0] cpsr_r;
    logic        err_r;
    logic [31:0] cpsr_next_s;
    logic        err_s;
    logic        bank_we_s;
    logic [4:0]  bank_wmode_s;
    logic [31:0] bank_wdata_s;
    logic [31:0] bank_rdata_s;
    logic        bank_legal_s;
    logic [4:0]  cur_mode_s;
    logic [3:0]  cpsr_fields_s;

    assign cur_mode_s = cpsr_r[CPSR_M_HI:CPSR_M_LO];

    // USR may only touch the flag byte; a c-lane write carrying an illegal
    // mode is dropped as a whole so the CPSR can never hold a bad mode.
    always_comb begin
        cpsr_fields_s = msr_fields;
        if (cur_mode_s == MODE_USR) begin
            cpsr_fields_s = msr_fields & 4'b1000;
        end else if (!mode_legal(msr_data[4:0])) begin
            cpsr_fields_s = msr_fields & 4'b1110;
        end else begin
            cpsr_fields_s = msr_fields;
        end
    end

    // Next-state selection: exactly one action per cycle, highest priority wins.
    always_comb begin
        cpsr_next_s  = cpsr_r;
        err_s        = 1'b0;
        bank_we_s    = 1'b0;
        bank_wmode_s = exc_mode;
        bank_wdata_s = cpsr_r;
        if (reset) begin
            cpsr_next_s = RESET_CPSR;
        end else if (exc_req) begin
            if (mode_banked(exc_mode)) begin
                bank_we_s    = 1'b1;
                bank_wmode_s = exc_mode;
                bank_wdata_s = cpsr_r;
                cpsr_next_s[CPSR_M_HI:CPSR_M_LO] = exc_mode;
                cpsr_next_s[CPSR_I] = 1'b1;
                cpsr_next_s[CPSR_F] = cpsr_r[CPSR_F] | exc_fiq;
                cpsr_next_s[CPSR_T] = 1'b0;
            end else begin
                err_s = 1'b1;
            end
        end else if (exc_ret && inst_valid) begin
            if (bank_legal_s && mode_banked(cur_mode_s)) begin
                cpsr_next_s = bank_rdata_s;
            end else begin
                err_s = 1'b1;
            end
        end else if (msr_we && inst_valid && !msr_spsr) begin
            cpsr_next_s = lane_merge(cpsr_r, msr_data, cpsr_fields_s);
        end else if (msr_we && inst_valid && msr_spsr) begin
            if (mode_banked(cur_mode_s)) begin
                bank_we_s    = 1'b1;
                bank_wmode_s = cur_mode_s;
                bank_wdata_s = lane_merge(bank_rdata_s, msr_data, msr_fields);
            end else begin
                bank_we_s = 1'b0;
            end
        end else if (flag_we && inst_valid) begin
            for (int i = 0; i < 4; i++) begin
                if (nzcv_mask[i]) begin
                    cpsr_next_s[CPSR_V + i] = alu_nzcv[i];
                end else begin
                    cpsr_next_s[CPSR_V + i] = cpsr_r[CPSR_V + i];
                end
            end
        end else begin
            cpsr_next_s = cpsr_r;
        end
    end

    // CPSR and error-pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpsr_r <= RESET_CPSR;
            err_r  <= 1'b0;
        end else begin
            cpsr_r <= cpsr_next_s;
            err_r  <= err_s;
        end
    end

    cpsr_unit_spsr_bank u_spsr_bank (
        .clk     (clk),
        .reset   (reset),
        .we      (bank_we_s),
        .wmode   (bank_wmode_s),
        .wdata   (bank_wdata_s),
        .rd_mode (cur_mode_s),
        .rd_data (bank_rdata_s),
        .legal   (bank_legal_s)
    );

    assign cpsr      = cpsr_r;
    assign cpsr_next = cpsr_next_s;
    assign spsr      = bank_rdata_s;
    assign exc_err   = err_r;

endmodule

// File: tb/tb_cpsr_unit.sv
// Bench for cpsr_unit: a mode-indexed reference model checked every cycle,
// plus directed steps with hand-computed literal expectations.
module tb_cpsr_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid, flag_we, msr_we, msr_spsr, exc_req, exc_fiq, exc_ret;
    logic [3:0]  alu_nzcv, nzcv_mask, msr_fields;
    logic [31:0] msr_data;
    logic [4:0]  exc_mode;
    logic [31:0] cpsr, cpsr_next, spsr;
    logic        exc_err;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    // Reference model state: SPSRs stored directly by mode number.
    logic [31:0] m_cpsr;
    logic [31:0] m_spsr [32];
    logic        m_err;

    always #5 clk = ~clk;

    cpsr_unit dut (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .flag_we(flag_we),
        .alu_nzcv(alu_nzcv), .nzcv_mask(nzcv_mask), .msr_we(msr_we),
        .msr_spsr(msr_spsr), .msr_fields(msr_fields), .msr_data(msr_data),
        .exc_req(exc_req), .exc_mode(exc_mode), .exc_fiq(exc_fiq),
        .exc_ret(exc_ret), .cpsr(cpsr), .cpsr_next(cpsr_next), .spsr(spsr),
        .exc_err(exc_err)
    );

    function automatic bit is_legal(input logic [4:0] m);
        return m inside {5'h10, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h1F};
    endfunction

    function automatic bit has_spsr(input logic [4:0] m);
        return is_legal(m) && !(m inside {5'h10, 5'h1F});
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] f);
        logic [31:0] mk;
        mk = 32'd0;
        for (int b = 0; b < 4; b++) if (f[b]) mk[b*8 +: 8] = 8'hFF;
        return mk;
    endfunction

    // Spec-level next-state evaluation from model state and current inputs.
    task automatic model_eval(output logic [31:0] nxt, output logic err,
                              output logic sw, output logic [4:0] sm,
                              output logic [31:0] sd);
        logic [4:0]  mode;
        logic [31:0] mk;
        mode = m_cpsr[4:0];
        nxt = m_cpsr; err = 1'b0; sw = 1'b0; sm = 5'd0; sd = 32'd0;
        if (reset) begin
            nxt = 32'h0000_00D3;
        end else if (exc_req) begin
            if (has_spsr(exc_mode)) begin
                sw = 1'b1; sm = exc_mode; sd = m_cpsr;
                nxt = {m_cpsr[31:8], 1'b1, m_cpsr[6] | exc_fiq, 1'b0, exc_mode};
            end else err = 1'b1;
        end else if (exc_ret && inst_valid) begin
            if (has_spsr(mode)) nxt = m_spsr[mode];
            else err = 1'b1;
        end else if (msr_we && inst_valid) begin
            mk = lane_mask(msr_fields);
            if (!msr_spsr) begin
                if (mode == 5'h10) mk = mk & 32'hFF00_0000;
                if (!is_legal(msr_data[4:0])) mk = mk & 32'hFFFF_FF00;
                nxt = (m_cpsr & ~mk) | (msr_data & mk);
            end else if (has_spsr(mode)) begin
                sw = 1'b1; sm = mode;
                sd = (m_spsr[mode] & ~mk) | (msr_data & mk);
            end
        end else if (flag_we && inst_valid) begin
            for (int i = 0; i < 4; i++) if (nzcv_mask[i]) nxt[28 + i] = alu_nzcv[i];
        end
    endtask

    // Advance the model on each rising edge.
    always @(posedge clk) begin
        logic [31:0] nxt, sd;
        logic        err, sw;
        logic [4:0]  sm;
        model_eval(nxt, err, sw, sm, sd);
        if (reset) begin
            for (int k = 0; k < 32; k++) m_spsr[k] = 32'd0;
            m_cpsr = 32'h0000_00D3;
            m_err  = 1'b0;
        end else begin
            if (sw) m_spsr[sm] = sd;
            m_cpsr = nxt;
            m_err  = err;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Compare DUT against the model on every falling edge once reset was seen.
    always @(negedge clk) begin
        logic [31:0] nxt, sd, exp_spsr;
        logic        err, sw;
        logic [4:0]  sm;
        if (chk_en) begin
            model_eval(nxt, err, sw, sm, sd);
            exp_spsr = has_spsr(m_cpsr[4:0]) ? m_spsr[m_cpsr[4:0]] : 32'd0;
            check("model_cpsr", cpsr, m_cpsr);
            check("model_cpsr_next", cpsr_next, nxt);
            check("model_spsr", spsr, exp_spsr);
            check("model_exc_err", {31'd0, exc_err}, {31'd0, m_err});
        end
    end

    task automatic idle();
        inst_valid = 1'b0; flag_we = 1'b0; msr_we = 1'b0; msr_spsr = 1'b0;
        exc_req = 1'b0; exc_fiq = 1'b0; exc_ret = 1'b0;
        alu_nzcv = 4'd0; nzcv_mask = 4'd0; msr_fields = 4'd0;
        msr_data = 32'd0; exc_mode = 5'd0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic msr(input logic to_spsr, input logic [3:0] f, input logic [31:0] d);
        idle(); inst_valid = 1'b1; msr_we = 1'b1; msr_spsr = to_spsr;
        msr_fields = f; msr_data = d;
    endtask

    task automatic exc(input logic [4:0] m, input logic fiq);
        idle(); exc_req = 1'b1; exc_mode = m; exc_fiq = fiq;
    endtask

    task automatic ret();
        idle(); inst_valid = 1'b1; exc_ret = 1'b1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        step(); step();
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_cpsr_next", cpsr_next, 32'h0000_00D3);
        check("reset_cpsr", cpsr, 32'h0000_00D3);
        check("reset_spsr", spsr, 32'd0);
        check("reset_err", {31'd0, exc_err}, 32'd0);

        // Flag update in SVC.
        step(); reset = 1'b0;
        idle(); inst_valid = 1'b1; flag_we = 1'b1; alu_nzcv = 4'b0110; nzcv_mask = 4'b1110;
        @(negedge clk);
        check("flag_bypass", {28'd0, cpsr_next[31:28]}, 32'h6);
        step(); inst_valid = 1'b0; alu_nzcv = 4'b1111; nzcv_mask = 4'b1111;
        @(negedge clk);
        check("flag_cpsr", cpsr, 32'h6000_00D3);
        check("flag_dropped_next", cpsr_next, 32'h6000_00D3);
        step(); idle();
        @(negedge clk);
        check("flag_dropped", cpsr, 32'h6000_00D3);
        check("model_pin_flag", m_cpsr, 32'h6000_00D3);

        // Enter USR via MSR, then IRQ entry and return.
        msr(1'b0, 4'b1001, 32'h2000_0010);
        step(); exc(5'b10010, 1'b0);
        @(negedge clk);
        check("msr_to_usr", cpsr, 32'h2000_0010);
        step(); idle();
        @(negedge clk);
        check("irq_cpsr", cpsr, 32'h2000_0092);
        check("irq_spsr", spsr, 32'h2000_0010);
        ret();
        step(); idle();
        @(negedge clk);
        check("irq_ret", cpsr, 32'h2000_0010);
        check("usr_spsr_zero", spsr, 32'd0);

        // USR may only write the flag byte.
        msr(1'b0, 4'b1001, 32'hF000_00D3);
        step(); exc(5'b00000, 1'b0);
        @(negedge clk);
        check("usr_msr", cpsr, 32'hF000_0010);
        step(); ret();
        @(negedge clk);
        check("illegal_exc_err", {31'd0, exc_err}, 32'd1);
        check("illegal_exc_cpsr", cpsr, 32'hF000_0010);
        step(); idle();
        @(negedge clk);
        check("usr_ret_err", {31'd0, exc_err}, 32'd1);
        step();
        @(negedge clk);
        check("err_one_cycle", {31'd0, exc_err}, 32'd0);

        // SVC entry from USR, then MSR to SYS, illegal c-lane, return in SYS.
        exc(5'b10011, 1'b0);
        step(); msr(1'b0, 4'b0001, 32'h0000_001F);
        @(negedge clk);
        check("svc_entry", cpsr, 32'hF000_0093);
        step(); msr(1'b0, 4'b0001, 32'h0000_0015);
        @(negedge clk);
        check("msr_to_sys", cpsr, 32'hF000_001F);
        step(); ret();
        @(negedge clk);
        check("illegal_clane", cpsr, 32'hF000_001F);
        step(); msr(1'b1, 4'b1111, 32'h1234_5678);
        @(negedge clk);
        check("sys_ret_err", {31'd0, exc_err}, 32'd1);
        check("sys_ret_cpsr", cpsr, 32'hF000_001F);
        step(); exc(5'b10011, 1'b0);
        step(); msr(1'b1, 4'b1000, 32'h0A00_0000);
        step(); idle();
        @(negedge clk);
        check("msr_spsr", spsr, 32'h0A00_001F);

        // Simultaneous requests: only FIQ entry applies.
        reset = 1'b1;
        step(); reset = 1'b0;
        exc(5'b10001, 1'b1); inst_valid = 1'b1; flag_we = 1'b1;
        alu_nzcv = 4'b1111; nzcv_mask = 4'b1111;
        msr_we = 1'b1; msr_fields = 4'b1111; msr_data = 32'h0000_0000;
        step(); reset = 1'b1;
        @(negedge clk);
        check("simul_cpsr", cpsr, 32'h0000_00D1);
        check("simul_spsr_fiq", spsr, 32'h0000_00D3);
        check("reset_over_req_next", cpsr_next, 32'h0000_00D3);
        step(); reset = 1'b0; idle();
        @(negedge clk);
        check("reset_restore", cpsr, 32'h0000_00D3);
        check("reset_spsr_clear", spsr, 32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
